// File: rtl/sid_i2s_out.sv
// Boxcar decimator -> 4-deep sample FIFO -> Philips I2S serializer (mono on both channels).
// Push lands one clk after the final strobe; a full FIFO drops new samples, an empty one repeats the last.
module sid_i2s_out #(
  parameter int DECIM_LOG2 = 4,
  parameter int BCLK_DIV   = 6
) (
  input  logic               clk,
  input  logic               iRst,
  input  logic               clkEn,
  input  logic signed [15:0] iSample,
  input  logic               iClearFlags,
  output logic               oBclk,
  output logic               oLrclk,
  output logic               oSdata,
  output logic [2:0]         oLevel,
  output logic               oOverflow,
  output logic               oUnderflow
);

  localparam int AW = 16 + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic signed [AW-1:0] acc_q, acc_d, acc_sum, acc_shr;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 push;
  logic [15:0]          push_dat;

  logic [15:0]          mem_q [4];
  logic [1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [2:0]           lvl_q, lvl_d;
  logic                 pop, pop_ok, push_ok;

  logic [DW-1:0]        div_q, div_d;
  logic                 bclk_q, bclk_d, lr_q, lr_d, sd_q, sd_d;
  logic [4:0]           slot_q, slot_d, slot_nxt;
  logic [15:0]          hold_q, hold_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 fall;

  always_comb begin
    acc_sum  = acc_q + AW'(iSample);
    acc_shr  = acc_sum >>> DECIM_LOG2;
    push_dat = acc_shr[15:0];
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    if (clkEn) begin
      if (cnt_q == CNT_LAST) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    div_d    = div_q + 1'b1;
    bclk_d   = bclk_q;
    fall     = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end
    slot_nxt = slot_q + 5'd1;
    pop      = fall && (slot_q == 5'd31);
    // A pop never sees a same-cycle push: occupancy is judged on the registered level.
    pop_ok   = pop && (lvl_q != 3'd0);
    push_ok  = push && ((lvl_q != 3'd4) || pop_ok);
    wr_d     = push_ok ? wr_q + 2'd1 : wr_q;
    rd_d     = pop_ok ? rd_q + 2'd1 : rd_q;
    lvl_d    = lvl_q + {2'b00, push_ok} - {2'b00, pop_ok};
    hold_d   = pop_ok ? mem_q[rd_q] : hold_q;
    slot_d   = slot_q;
    lr_d     = lr_q;
    sd_d     = sd_q;
    if (fall) begin
      slot_d = slot_nxt;
      lr_d   = (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);
      sd_d   = hold_d[~slot_nxt[3:0]];
    end
    ovf_d    = (push && !push_ok) || (ovf_q && !iClearFlags);
    unf_d    = (pop && !pop_ok) || (unf_q && !iClearFlags);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      div_q  <= '0;
      bclk_q <= 1'b0;
      lr_q   <= 1'b0;
      sd_q   <= 1'b0;
      slot_q <= 5'd31;
      hold_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      div_q  <= div_d;
      bclk_q <= bclk_d;
      lr_q   <= lr_d;
      sd_q   <= sd_d;
      slot_q <= slot_d;
      hold_q <= hold_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign oBclk      = bclk_q;
  assign oLrclk     = lr_q;
  assign oSdata     = sd_q;
  assign oLevel     = lvl_q;
  assign oOverflow  = ovf_q;
  assign oUnderflow = unf_q;

endmodule

// File: tb/tb_sid_i2s_out.sv
// Directed bench for sid_i2s_out (DECIM_LOG2=4, BCLK_DIV=6): frames are captured on BCLK rises.
module tb_sid_i2s_out;

  logic        clk = 1'b0;
  logic        iRst = 1'b1;
  logic        clkEn = 1'b0;
  logic [15:0] iSample = '0;
  logic        iClearFlags = 1'b0;
  logic        oBclk, oLrclk, oSdata, oOverflow, oUnderflow;
  logic [2:0]  oLevel;

  int n_chk = 0;
  int n_err = 0;
  int tb_slot = 31;

  localparam logic [31:0] LR_EXP = 32'h0001FFFE;

  sid_i2s_out #(.DECIM_LOG2(4), .BCLK_DIV(6)) dut (
    .clk(clk), .iRst(iRst), .clkEn(clkEn), .iSample(iSample), .iClearFlags(iClearFlags),
    .oBclk(oBclk), .oLrclk(oLrclk), .oSdata(oSdata), .oLevel(oLevel),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 clk = ~clk;

  always @(negedge oBclk or posedge iRst) begin
    if (iRst) tb_slot <= 31;
    else      tb_slot <= (tb_slot + 1) % 32;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v, input int n, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clkEn = 1'b1;
      iSample = v;
      iClearFlags = clr_last && (i == n - 1);
    end
    @(negedge clk);
    clkEn = 1'b0;
    iClearFlags = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk) iClearFlags = 1'b1;
    @(negedge clk) iClearFlags = 1'b0;
  endtask

  // Returns #1 after the clk edge on which the slot counter enters slot n.
  task automatic wait_slot(input int n);
    bit ok = 1'b0;
    int prev = tb_slot;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (tb_slot == n && prev != n) begin ok = 1'b1; break; end
      prev = tb_slot;
    end
    if (!ok) chk("wait_slot_timeout", 32'd0, 32'd1);
  endtask

  // Called just after reset release; counts clk edges to the first BCLK rise and fall.
  task automatic first_edges(output int rise, output int fall);
    rise = 0;
    fall = 0;
    for (int n = 1; n < 100; n++) begin
      @(posedge clk); #1;
      if (rise == 0 && oBclk) rise = n;
      if (rise != 0 && !oBclk) begin fall = n; break; end
    end
  endtask

  // Called just after the fall into slot 0; returns just after the next fall into slot 0.
  task automatic capture(output logic [31:0] d, output logic [31:0] lr);
    int s = 0;
    bit done = 1'b0;
    logic prev = oBclk;
    d = '0;
    lr = '0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (oBclk && !prev && s < 32) begin
        d[31-s] = oSdata;
        lr[31-s] = oLrclk;
        s++;
      end else if (!oBclk && prev && s == 32) begin
        done = 1'b1;
      end
      prev = oBclk;
      if (done) break;
    end
    if (!done) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] d, lr;
  int rise, fall;
  logic [15:0] exp_seq [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd7};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {24'd0, oBclk, oLrclk, oSdata, oLevel, oOverflow, oUnderflow}, 32'd0);
    @(negedge clk) iRst = 1'b0;
    first_edges(rise, fall);
    chk("first_rise", rise, 6);
    chk("first_fall", fall, 12);
    chk("unf_first_load", oUnderflow, 1);

    fork
      capture(d, lr);
      begin
        clr();
        chk("unf_cleared", oUnderflow, 0);
        push(16'h1000, 16, 1'b0);
        chk("level_after_1000", oLevel, 1);
        push(16'h7FFF, 8, 1'b0);
        chk("level_mid_block", oLevel, 1);
        push(16'h8000, 8, 1'b0);
        chk("level_after_mixed", oLevel, 2);
      end
    join
    chk("frame0_zero", d, 32'h0);
    chk("frame0_lrclk", lr, LR_EXP);
    chk("pop_level", oLevel, 1);
    chk("no_unf_on_load", oUnderflow, 0);

    fork
      capture(d, lr);
      push(16'hA5C3, 16, 1'b0);
    join
    chk("frame_1000", d, 32'h10001000);
    capture(d, lr);
    chk("frame_neg_floor", d, 32'hFFFFFFFF);
    chk("level_before_ovf", oLevel, 0);

    fork
      capture(d, lr);
      begin
        for (int v = 1; v <= 4; v++) push(16'(v), 16, 1'b0);
        chk("level_full", oLevel, 4);
        chk("ovf_not_yet", oOverflow, 0);
        push(16'd5, 16, 1'b0);
        chk("level_after_drop", oLevel, 4);
        chk("ovf_set", oOverflow, 1);
        clr();
        chk("ovf_cleared", oOverflow, 0);
        push(16'd6, 16, 1'b1);
        chk("ovf_set_beats_clear", oOverflow, 1);
        clr();
        wait_slot(30);
        repeat (8) @(negedge clk);
        push(16'd7, 16, 1'b0);
        chk("full_push_with_pop_level", oLevel, 4);
        chk("full_push_with_pop_ovf", oOverflow, 0);
      end
    join
    chk("serial_a5c3", d, 32'hA5C3A5C3);
    chk("serial_lrclk", lr, LR_EXP);

    for (int i = 0; i < 4; i++) begin
      capture(d, lr);
      chk($sformatf("fifo_order_%0d", i), d, {exp_seq[i], exp_seq[i]});
    end
    chk("no_unf_while_busy", oUnderflow, 0);
    fork
      capture(d, lr);
      begin
        wait_slot(30);
        repeat (8) @(negedge clk);
        push(16'h0055, 16, 1'b0);
        chk("empty_pop_push_level", oLevel, 1);
        chk("empty_pop_push_unf", oUnderflow, 1);
      end
    join
    chk("fifo_order_4", d, {exp_seq[4], exp_seq[4]});
    capture(d, lr);
    chk("underflow_repeats_hold", d, 32'h00070007);
    capture(d, lr);
    chk("push_not_bypassed", d, 32'h00550055);

    push(16'h1234, 16, 1'b0);
    push(16'h4000, 5, 1'b0);
    chk("level_before_rst", oLevel, 1);
    wait_slot(7);
    @(posedge clk); #2;
    iRst = 1'b1;
    #1;
    chk("async_rst_outputs", {24'd0, oBclk, oLrclk, oSdata, oLevel, oOverflow, oUnderflow}, 32'd0);
    @(negedge clk) iRst = 1'b0;
    first_edges(rise, fall);
    chk("rst2_first_rise", rise, 6);
    chk("rst2_first_fall", fall, 12);
    chk("rst2_level", oLevel, 0);
    chk("rst2_unf", oUnderflow, 1);
    fork
      capture(d, lr);
      begin
        push(16'h0100, 16, 1'b0);
        chk("rst2_push_level", oLevel, 1);
      end
    join
    chk("rst2_hold_zero", d, 32'h0);
    capture(d, lr);
    chk("rst2_acc_cleared", d, 32'h01000100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
